// File: rtl/pkt_tx_sched.sv
// Transmit scheduler: round-robin over NUM_REQ requesters plus a priority kill source,
// emitting 8-byte radio frames. Optional stall watchdog enabled by PKT_TX_WDOG_EN.
//
// state | meaning
// IDLE  | waiting for kill_req or a requester; grant/ack decoded combinationally
// SEND  | presenting frame bytes B0..B7 on tx_frame
// GAP   | forced inter-frame idle, gap_cnt counts down to zero
module pkt_tx_sched #(
  parameter int         NUM_REQ     = 4,
  parameter logic [7:0] SYNC0       = 8'hA5,
  parameter logic [7:0] SYNC1       = 8'h5A,
  parameter int         IFG_CYCLES  = 4,
  parameter int         WDOG_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            own_id,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [8*NUM_REQ-1:0]  req_dst,
  input  logic [16*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  kill_req,
  output logic                  kill_ack,
  output logic [7:0]            tx_frame,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  tx_abort
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(IFG_CYCLES + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("pkt_tx_sched: NUM_REQ must be 2..8");
  end
  if (IFG_CYCLES < 1) begin : g_bad_ifg
    $error("pkt_tx_sched: IFG_CYCLES must be >= 1");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("pkt_tx_sched: WDOG_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;
  logic [2:0]       byte_idx;
  logic [2:0]       nxt_idx;
  logic [7:0]       seq;
  logic [7:0]       dst_q;
  logic [7:0]       src_q;
  logic [15:0]      data_q;
  logic             kill_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       chk;
  logic [7:0]       next_byte;
  logic             idle_ok;
  logic             take_kill;
  logic             take_req;

`ifdef PKT_TX_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0]  wdog_cnt;
  logic             abort_q;
  assign tx_abort = abort_q;
`else
  assign tx_abort = 1'b0;
`endif

  // First pending requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Grant is masked while reset is asserted so nothing transfers during reset.
  assign idle_ok   = rst && (state == IDLE);
  assign take_kill = idle_ok && kill_req;
  assign take_req  = idle_ok && !kill_req && grant_found;
  assign kill_ack  = take_kill;
  assign busy      = (state != IDLE);

  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready[k] = take_req && (grant_idx == IDX_W'(k));
    end
  end

  assign chk     = dst_q ^ src_q ^ data_q[15:8] ^ data_q[7:0] ^ seq;
  assign nxt_idx = byte_idx + 3'd1;

  always_comb begin
    next_byte = 8'h00;
    case (nxt_idx)
      3'd0: next_byte = SYNC0;
      3'd1: next_byte = SYNC1;
      3'd2: next_byte = dst_q;
      3'd3: next_byte = src_q;
      3'd4: next_byte = data_q[15:8];
      3'd5: next_byte = data_q[7:0];
      3'd6: next_byte = seq;
      3'd7: next_byte = chk;
      default: next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      seq      <= 8'h00;
      gap_cnt  <= '0;
      byte_idx <= 3'd0;
      tx_valid <= 1'b0;
      tx_frame <= 8'h00;
      dst_q    <= 8'h00;
      src_q    <= 8'h00;
      data_q   <= 16'h0000;
      kill_q   <= 1'b0;
`ifdef PKT_TX_WDOG_EN
      wdog_cnt <= '0;
      abort_q  <= 1'b0;
`endif
    end else begin
`ifdef PKT_TX_WDOG_EN
      abort_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (take_kill) begin
            dst_q    <= 8'hFF;
            src_q    <= 8'hFF;
            data_q   <= 16'hFFFF;
            kill_q   <= 1'b1;
            state    <= SEND;
            byte_idx <= 3'd0;
            tx_valid <= 1'b1;
            tx_frame <= SYNC0;
`ifdef PKT_TX_WDOG_EN
            wdog_cnt <= WD_W'(WDOG_CYCLES);
`endif
          end else if (take_req) begin
            dst_q    <= req_dst[8*grant_idx +: 8];
            src_q    <= own_id;
            data_q   <= req_data[16*grant_idx +: 16];
            kill_q   <= 1'b0;
            rr_ptr   <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            state    <= SEND;
            byte_idx <= 3'd0;
            tx_valid <= 1'b1;
            tx_frame <= SYNC0;
`ifdef PKT_TX_WDOG_EN
            wdog_cnt <= WD_W'(WDOG_CYCLES);
`endif
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (byte_idx == 3'd7) begin
              tx_valid <= 1'b0;
              tx_frame <= 8'h00;
              state    <= GAP;
              gap_cnt  <= GAP_W'(IFG_CYCLES);
              if (!kill_q) seq <= seq + 8'd1;
            end else begin
              byte_idx <= nxt_idx;
              tx_frame <= next_byte;
`ifdef PKT_TX_WDOG_EN
              wdog_cnt <= WD_W'(WDOG_CYCLES);
`endif
            end
          end
`ifdef PKT_TX_WDOG_EN
          // Stalled: abort on the WDOG_CYCLES-th consecutive refused cycle.
          else if (wdog_cnt <= WD_W'(1)) begin
            abort_q  <= 1'b1;
            tx_valid <= 1'b0;
            tx_frame <= 8'h00;
            state    <= GAP;
            gap_cnt  <= GAP_W'(IFG_CYCLES);
          end else begin
            wdog_cnt <= wdog_cnt - 1'b1;
          end
`endif
        end
        GAP: begin
          if (gap_cnt <= GAP_W'(1)) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_tx_sched.sv
// Directed self-checking bench for pkt_tx_sched: inputs driven 1 time unit after
// posedge, outputs and transfers observed on negedge.
module tb_pkt_tx_sched;

  localparam int N   = 4;
  localparam int IFG = 4;
  localparam int WD  = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [7:0]     own_id = 8'h03;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_dst = {8'h13, 8'h12, 8'h11, 8'h07};
  logic [16*N-1:0] req_data = {16'hC303, 16'hC202, 16'hC101, 16'hBEEF};
  logic [N-1:0]   req_ready;
  logic           kill_req = 1'b0;
  logic           kill_ack;
  logic [7:0]     tx_frame;
  logic           tx_valid;
  logic           tx_ready = 1'b1;
  logic           busy;
  logic           tx_abort;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] byte_q[$];
  int         byte_cyc_q[$];
  int         grant_q[$];
  int         grant_cyc_q[$];

  pkt_tx_sched #(
    .NUM_REQ(N), .SYNC0(8'hA5), .SYNC1(8'h5A), .IFG_CYCLES(IFG), .WDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .rst(rst), .own_id(own_id), .req_valid(req_valid), .req_dst(req_dst),
    .req_data(req_data), .req_ready(req_ready), .kill_req(kill_req), .kill_ack(kill_ack),
    .tx_frame(tx_frame), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .tx_abort(tx_abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transfer monitor: inputs are stable from posedge+1 through the next posedge.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      byte_q.push_back(tx_frame);
      byte_cyc_q.push_back(cyc);
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        grant_q.push_back(i);
        grant_cyc_q.push_back(cyc);
      end
    end
    if (kill_ack) begin
      grant_q.push_back(-1);
      grant_cyc_q.push_back(cyc);
    end
  end

  function automatic logic [7:0] qb(input int i);
    return (i < byte_q.size()) ? byte_q[i] : 8'hxx;
  endfunction
  function automatic int qc(input int i);
    return (i < byte_cyc_q.size()) ? byte_cyc_q[i] : -1000;
  endfunction
  function automatic int qg(input int i);
    return (i < grant_q.size()) ? grant_q[i] : -99;
  endfunction
  function automatic int qgc(input int i);
    return (i < grant_cyc_q.size()) ? grant_cyc_q[i] : -1000;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    byte_q.delete();
    byte_cyc_q.delete();
    grant_q.delete();
    grant_cyc_q.delete();
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (byte_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      next_cycle();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      next_cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({tx_valid, tx_frame, req_ready, kill_ack, busy, tx_abort} !== 16'h0000) begin
        bad++;
        $display("FAIL reset_outputs cycle %0d: got %h required 0000", i,
                 {tx_valid, tx_frame, req_ready, kill_ack, busy, tx_abort});
      end
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL reset_release_grant: got %b required 0001", req_ready);
    end
    #1 req_valid = '0;
    next_cycle();
    clear_logs();
  endtask

  task automatic test_single_frame();
    logic [7:0] exp [8];
    bit ok;
    exp = '{8'hA5, 8'h5A, 8'h07, 8'h03, 8'hBE, 8'hEF, 8'h00, 8'h55};
    req_valid = 4'b0001;
    next_cycle();
    req_valid = '0;
    wait_bytes(8, 40, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_timeout: got %0d bytes required 8", byte_q.size()); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (qb(i) !== exp[i]) begin
        bad++;
        $display("FAIL single_byte%0d: got %h required %h", i, qb(i), exp[i]);
      end
    end
    total++;
    if (qc(0) - qgc(0) !== 1) begin
      bad++;
      $display("FAIL single_latency: got %0d required 1", qc(0) - qgc(0));
    end
    total++;
    if (qc(7) - qc(0) !== 7) begin
      bad++;
      $display("FAIL single_consecutive: got %0d required 7", qc(7) - qc(0));
    end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_gap: got %b required 1", busy); end
    wait_idle(ok);
    clear_logs();
  endtask

  task automatic test_round_robin();
    bit ok;
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    clear_logs();
    req_valid = 4'hF;
    wait_bytes(40, 400, ok);
    req_valid = '0;
    total++;
    if (!ok) begin bad++; $display("FAIL rr_timeout: got %0d bytes required 40", byte_q.size()); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (qg(k) !== k % N) begin
        bad++;
        $display("FAIL rr_grant%0d: got %0d required %0d", k, qg(k), k % N);
      end
    end
    total++;
    if (qc(8) - qc(7) !== IFG + 2) begin
      bad++;
      $display("FAIL rr_ifg: got %0d required %0d", qc(8) - qc(7), IFG + 2);
    end
    total++;
    if (qb(18) !== 8'h12) begin bad++; $display("FAIL rr_dst2: got %h required 12", qb(18)); end
    total++;
    if (qb(15) !== 8'hD3) begin bad++; $display("FAIL rr_chk1: got %h required d3", qb(15)); end
    total++;
    if (qb(38) !== 8'h04) begin bad++; $display("FAIL rr_seq4: got %h required 04", qb(38)); end
    wait_idle(ok);
    clear_logs();
  endtask

  task automatic test_kill();
    logic [7:0] exp [8];
    bit ok;
    exp = '{8'hA5, 8'h5A, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h05, 8'h05};
    kill_req  = 1'b1;
    req_valid = 4'b0010;
    @(negedge clk);
    total++;
    if ({kill_ack, req_ready} !== 5'b1_0000) begin
      bad++;
      $display("FAIL kill_ack_priority: got %b required 10000", {kill_ack, req_ready});
    end
    next_cycle();
    kill_req = 1'b0;
    wait_bytes(16, 200, ok);
    req_valid = '0;
    total++;
    if (!ok) begin bad++; $display("FAIL kill_timeout: got %0d bytes required 16", byte_q.size()); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (qb(i) !== exp[i]) begin
        bad++;
        $display("FAIL kill_byte%0d: got %h required %h", i, qb(i), exp[i]);
      end
    end
    total++;
    if ({qg(0), qg(1)} !== {-32'sd1, 32'sd1}) begin
      bad++;
      $display("FAIL kill_order: got %0d,%0d required -1,1", qg(0), qg(1));
    end
    total++;
    if ({qb(10), qb(14), qb(15)} !== {8'h11, 8'h05, 8'hD7}) begin
      bad++;
      $display("FAIL kill_next_req1: got %h %h %h required 11 05 d7", qb(10), qb(14), qb(15));
    end
    wait_idle(ok);
    clear_logs();
  endtask

  task automatic test_stall();
    bit ok;
    req_valid = 4'b0001;
    next_cycle();
    req_valid = '0;
    wait_bytes(3, 40, ok);
    tx_ready = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL stall_timeout: got %0d bytes required 3", byte_q.size()); end
`ifdef PKT_TX_WDOG_EN
    begin
      int aborts = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (tx_abort) aborts++;
      end
      total++;
      if (aborts !== 1) begin bad++; $display("FAIL wdog_abort_pulses: got %0d required 1", aborts); end
      total++;
      if ({tx_valid, byte_q.size() == 3} !== 2'b01) begin
        bad++;
        $display("FAIL wdog_drop: got valid=%b bytes=%0d required valid=0 bytes=3", tx_valid, byte_q.size());
      end
    end
    next_cycle();
    tx_ready = 1'b1;
    wait_idle(ok);
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if ({tx_valid, tx_frame} !== {1'b1, 8'h03}) begin
        bad++;
        $display("FAIL stall_hold%0d: got %b/%h required 1/03", i, tx_valid, tx_frame);
      end
    end
    next_cycle();
    tx_ready = 1'b1;
    wait_bytes(8, 40, ok);
    wait_idle(ok);
    total++;
    if (byte_q.size() !== 8) begin bad++; $display("FAIL stall_count: got %0d required 8", byte_q.size()); end
    total++;
    if ({qb(3), qb(4), qb(5), qb(6), qb(7)} !== {8'h03, 8'hBE, 8'hEF, 8'h06, 8'h53}) begin
      bad++;
      $display("FAIL stall_bytes: got %h %h %h %h %h required 03 be ef 06 53",
               qb(3), qb(4), qb(5), qb(6), qb(7));
    end
`endif
    clear_logs();
  endtask

  task automatic test_reset_midframe();
    bit ok;
    req_valid = 4'b0001;
    next_cycle();
    req_valid = '0;
    wait_bytes(5, 40, ok);
    rst = 1'b0;
    tx_ready = 1'b0;
    req_valid = 4'b0001;
    next_cycle();
    @(negedge clk);
    total++;
    if ({tx_valid, busy, req_ready} !== 6'b0) begin
      bad++;
      $display("FAIL midrst_outputs: got %b required 000000", {tx_valid, busy, req_ready});
    end
    next_cycle();
    rst = 1'b1;
    tx_ready = 1'b1;
    clear_logs();
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL midrst_grant: got %b required 0001", req_ready); end
    next_cycle();
    req_valid = '0;
    wait_bytes(8, 40, ok);
    total++;
    if ({qb(0), qb(6), qb(7)} !== {8'hA5, 8'h00, 8'h55}) begin
      bad++;
      $display("FAIL midrst_frame: got %h %h %h required a5 00 55", qb(0), qb(6), qb(7));
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_kill();
    test_stall();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
